// File: rtl/keypad_scan_entry.sv
// keypad_scan_entry
//   4x4 matrix keypad scanner with per-press debounce and an 8-nibble
//   digit-entry shift register. D0 is the newest digit, D7 the oldest;
//   D0..D7 feed the eight-digit seven-segment driver directly.
//
//   Columns are driven active-low one at a time; rows are active-low with
//   external pull-ups and are asynchronous to clk. All scan, debounce and
//   hold decisions are taken on prescaler ticks (one every SCAN_DIV clocks).
//
//   Optional build macro: KEYPAD_AUTOREPEAT_EN
//     When defined, a held key is re-accepted after REPEAT_DELAY ticks and
//     then every REPEAT_RATE ticks. When undefined, exactly one key is
//     accepted per press and the REPEAT_* parameters have no effect.
module keypad_scan_entry #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    input  logic       clear,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] D0,
    output logic [3:0] D1,
    output logic [3:0] D2,
    output logic [3:0] D3,
    output logic [3:0] D4,
    output logic [3:0] D5,
    output logic [3:0] D6,
    output logic [3:0] D7
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity check
    // ------------------------------------------------------------------
    if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_scan_entry: SCAN_DIV must be >= 2, other parameters >= 1");
    end

    // ------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_TICKS - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(RPT_MAX + 1);
`endif

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [3:0]    row_meta_q;
    logic [3:0]    row_s_q;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;

    state_t        state_q;
    logic [1:0]    col_idx_q;
    logic [1:0]    row_idx_q;
    logic [1:0]    row_idx;
    logic [3:0]    pat_q;
    logic [DW-1:0] deb_cnt_q;

    logic          accept;
    logic [3:0]    code;

    logic          key_valid_q;
    logic [3:0]    key_code_q;
    logic [31:0]   digits_q;

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [RW-1:0] rep_cnt_q;
    logic          rep_first_q;
    logic [RW-1:0] rep_cnt_inc;
    logic [RW-1:0] rep_limit;
`endif

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous row inputs (idle = high)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_q <= '1;
            row_s_q    <= '1;
        end else begin
            row_meta_q <= row;
            row_s_q    <= row_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Scan-rate prescaler: tick is high for one clock every SCAN_DIV clocks
    // ------------------------------------------------------------------
    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Row priority encode: lowest active row index wins
    // ------------------------------------------------------------------
    always_comb begin
        row_idx = 2'd3;
        if (!row_s_q[0]) begin
            row_idx = 2'd0;
        end else if (!row_s_q[1]) begin
            row_idx = 2'd1;
        end else if (!row_s_q[2]) begin
            row_idx = 2'd2;
        end
    end

    // The code is built from the latched row and the held column
    assign code = {row_idx_q, col_idx_q};

`ifdef KEYPAD_AUTOREPEAT_EN
    assign rep_cnt_inc = rep_cnt_q + RW'(1);
    assign rep_limit   = rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
`endif

    // ------------------------------------------------------------------
    // Accept decision for the current tick (debounce complete or repeat due)
    // ------------------------------------------------------------------
    always_comb begin
        accept = 1'b0;
        if (tick) begin
            if (state_q == DEBOUNCE && row_s_q == pat_q && deb_cnt_q == DEB_LAST) begin
                accept = 1'b1;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (state_q == HELD && row_s_q == pat_q && rep_cnt_inc == rep_limit) begin
                accept = 1'b1;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Scan / debounce / hold sequencer with registered key outputs.
    // deb_cnt_q doubles as the release counter while in HELD.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            col_idx_q   <= '0;
            row_idx_q   <= '0;
            pat_q       <= '1;
            deb_cnt_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= code;
            end

            if (tick) begin
                case (state_q)
                    SCAN: begin
                        if (row_s_q != 4'hF) begin
                            row_idx_q <= row_idx;
                            pat_q     <= row_s_q;
                            deb_cnt_q <= '0;
                            state_q   <= DEBOUNCE;
                        end else begin
                            col_idx_q <= col_idx_q + 2'd1;
                        end
                    end

                    DEBOUNCE: begin
                        if (row_s_q == pat_q) begin
                            if (deb_cnt_q == DEB_LAST) begin
                                state_q     <= HELD;
                                deb_cnt_q   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep_cnt_q   <= '0;
                                rep_first_q <= 1'b1;
`endif
                            end else begin
                                deb_cnt_q <= deb_cnt_q + DW'(1);
                            end
                        end else begin
                            state_q   <= SCAN;
                            col_idx_q <= col_idx_q + 2'd1;
                        end
                    end

                    HELD: begin
                        if (row_s_q == 4'hF) begin
                            if (deb_cnt_q == DEB_LAST) begin
                                state_q   <= SCAN;
                                col_idx_q <= col_idx_q + 2'd1;
                                deb_cnt_q <= '0;
                            end else begin
                                deb_cnt_q <= deb_cnt_q + DW'(1);
                            end
                        end else begin
                            deb_cnt_q <= '0;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (row_s_q != pat_q) begin
                            rep_cnt_q   <= '0;
                            rep_first_q <= 1'b1;
                        end else if (accept) begin
                            rep_cnt_q   <= '0;
                            rep_first_q <= 1'b0;
                        end else begin
                            rep_cnt_q   <= rep_cnt_inc;
                        end
`endif
                    end

                    default: begin
                        state_q <= SCAN;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit-entry shift register; clear takes priority over an accept
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= '0;
        end else if (clear) begin
            digits_q <= '0;
        end else if (accept) begin
            digits_q <= {digits_q[27:0], code};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign col       = ~(4'b0001 << col_idx_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

    assign D0 = digits_q[3:0];
    assign D1 = digits_q[7:4];
    assign D2 = digits_q[11:8];
    assign D3 = digits_q[15:12];
    assign D4 = digits_q[19:16];
    assign D5 = digits_q[23:20];
    assign D6 = digits_q[27:24];
    assign D7 = digits_q[31:28];

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Testbench for keypad_scan_entry (SCAN_DIV=4, DEBOUNCE_TICKS=3,
// REPEAT_DELAY=5, REPEAT_RATE=2). A small keypad model pulls a row low
// while the pressed key's column is driven; a row-override path lets the
// bench apply raw bounce patterns.
module tb_keypad_scan_entry;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] D0, D1, D2, D3, D4, D5, D6, D7;
    logic [31:0] dig;

    // keypad model controls
    logic       key_down = 1'b0;
    logic [3:0] key_sel = 4'h0;
    logic       row_force_en = 1'b0;
    logic [3:0] row_force = 4'hF;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    keypad_scan_entry #(
        .SCAN_DIV(4),
        .DEBOUNCE_TICKS(3),
        .REPEAT_DELAY(5),
        .REPEAT_RATE(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .row(row),
        .col(col),
        .clear(clear),
        .key_valid(key_valid),
        .key_code(key_code),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .D4(D4), .D5(D5), .D6(D6), .D7(D7)
    );

    always #5 clk = ~clk;

    assign dig = {D7, D6, D5, D4, D3, D2, D1, D0};

    // keypad matrix: selected key connects its row to its column
    always_comb begin
        if (row_force_en) begin
            row = row_force;
        end else if (key_down && col[key_sel[1:0]] == 1'b0) begin
            row = ~(4'b0001 << key_sel[3:2]);
        end else begin
            row = 4'hF;
        end
    end

    // count key_valid cycles
    always @(posedge clk) begin
        if (key_valid) pulses <= pulses + 1;
    end

    // hard time limit
    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit, got %0d checks, required completion", checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_tick();
        repeat (SCAN_DIV) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // press a key and wait (bounded) for the key_valid pulse; optionally
    // hold clear high until the accept edge has passed
    task automatic press_key(input logic [3:0] k, input logic hold_clear, output logic got);
        got      = 1'b0;
        key_sel  = k;
        key_down = 1'b1;
        clear    = hold_clear;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (key_valid) begin
                got = 1'b1;
                break;
            end
        end
        clear = 1'b0;
    endtask

    task automatic release_key();
        key_down = 1'b0;
        repeat (4) step_tick();
    endtask

    typedef struct packed {
        logic [3:0] key;
        logic [3:0] d0;
        logic [3:0] d1;
    } vec_t;

    vec_t       vecs [9];
    logic [3:0] col_exp [4];
    logic       got;
    logic       exp_v;
    int         p0;

    initial begin
        // shift sequence: key pressed, expected D0 and D1 afterwards
        vecs[0] = '{key: 4'h1, d0: 4'h1, d1: 4'h6};
        vecs[1] = '{key: 4'h2, d0: 4'h2, d1: 4'h1};
        vecs[2] = '{key: 4'h3, d0: 4'h3, d1: 4'h2};
        vecs[3] = '{key: 4'h4, d0: 4'h4, d1: 4'h3};
        vecs[4] = '{key: 4'h5, d0: 4'h5, d1: 4'h4};
        vecs[5] = '{key: 4'h6, d0: 4'h6, d1: 4'h5};
        vecs[6] = '{key: 4'h7, d0: 4'h7, d1: 4'h6};
        vecs[7] = '{key: 4'h8, d0: 4'h8, d1: 4'h7};
        vecs[8] = '{key: 4'h9, d0: 4'h9, d1: 4'h8};
        col_exp[0] = 4'b1101;
        col_exp[1] = 4'b1011;
        col_exp[2] = 4'b0111;
        col_exp[3] = 4'b1110;

        // ---- reset state and idle column sweep
        do_reset();
        chk("reset_col", 32'(col), 32'hE);
        chk("reset_digits", dig, 32'h0);
        chk("reset_key_code", 32'(key_code), 32'h0);
        chk("reset_key_valid", 32'(key_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step_tick();
            chk("sweep_col", 32'(col), 32'(col_exp[i]));
        end

        // ---- single press of key 6 (row1, col2): accept on the 10th tick
        key_sel  = 4'h6;
        key_down = 1'b1;
        for (int t = 5; t <= 9; t++) begin
            step_tick();
            chk("single_no_early_valid", 32'(key_valid), 32'h0);
        end
        step_tick();
        chk("single_valid", 32'(key_valid), 32'h1);
        chk("single_code", 32'(key_code), 32'h6);
        chk("single_digits", dig, 32'h6);
        key_down = 1'b0;
        @(negedge clk);
        chk("single_valid_one_cycle", 32'(key_valid), 32'h0);
        repeat (3) @(negedge clk);
        step_tick();
        chk("release_col_held", 32'(col), 32'b1011);
        step_tick();
        chk("release_col_advanced", 32'(col), 32'b0111);
        chk("single_pulse_count", 32'(pulses), 32'd1);

        // ---- shift sequence keys 1..9
        p0 = pulses;
        for (int i = 0; i < 9; i++) begin
            press_key(vecs[i].key, 1'b0, got);
            chk("seq_got_valid", 32'(got), 32'h1);
            chk("seq_key_code", 32'(key_code), 32'(vecs[i].key));
            chk("seq_d0", 32'(D0), 32'(vecs[i].d0));
            chk("seq_d1", 32'(D1), 32'(vecs[i].d1));
            release_key();
        end
        chk("seq_digits", dig, 32'h23456789);
        chk("seq_pulse_count", 32'(pulses - p0), 32'd9);

        // ---- bounce rejection: row low one tick, high one tick
        p0 = pulses;
        row_force_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            row_force = 4'b1110;
            step_tick();
            row_force = 4'hF;
            step_tick();
        end
        row_force_en = 1'b0;
        repeat (2) step_tick();
        chk("bounce_no_pulse", 32'(pulses - p0), 32'd0);
        chk("bounce_digits", dig, 32'h23456789);
        press_key(4'h0, 1'b0, got);
        chk("bounce_resume_got", 32'(got), 32'h1);
        chk("bounce_resume_d0", 32'(D0), 32'h0);
        chk("bounce_resume_d1", 32'(D1), 32'h9);
        release_key();

        // ---- clear coinciding with accept of key F
        p0 = pulses;
        press_key(4'hF, 1'b1, got);
        chk("clear_got", 32'(got), 32'h1);
        chk("clear_key_code", 32'(key_code), 32'hF);
        chk("clear_digits", dig, 32'h0);
        release_key();
        chk("clear_pulse_count", 32'(pulses - p0), 32'd1);

        // ---- reset in the middle of DEBOUNCE
        do_reset();
        chk("reset2_key_code", 32'(key_code), 32'h0);
        chk("reset2_col", 32'(col), 32'hE);
        key_sel  = 4'h0;
        key_down = 1'b1;
        step_tick();
        step_tick();
        p0 = pulses;
        key_down = 1'b0;
        do_reset();
        chk("midreset_col", 32'(col), 32'hE);
        step_tick();
        chk("midreset_scan_resumes", 32'(col), 32'b1101);
        repeat (5) step_tick();
        chk("midreset_no_pulse", 32'(pulses - p0), 32'd0);
        chk("midreset_digits", dig, 32'h0);

        // ---- hold key A for 12 ticks after accept
        p0 = pulses;
        press_key(4'hA, 1'b0, got);
        chk("hold_got", 32'(got), 32'h1);
        chk("hold_key_code", 32'(key_code), 32'hA);
        for (int t = 1; t <= 12; t++) begin
            step_tick();
`ifdef KEYPAD_AUTOREPEAT_EN
            exp_v = (t == 5 || t == 7 || t == 9 || t == 11);
`else
            exp_v = 1'b0;
`endif
            chk("hold_repeat_valid", 32'(key_valid), 32'(exp_v));
        end
        release_key();
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("hold_digits", dig, 32'h000AAAAA);
        chk("hold_pulse_count", 32'(pulses - p0), 32'd5);
`else
        chk("hold_digits", dig, 32'h0000000A);
        chk("hold_pulse_count", 32'(pulses - p0), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
